// File: rtl/ram_v_if.sv
// ram_v_if: bus bundle for the ram_v data memory.
// The master (CPU MEM stage) drives we/a/wd and samples rd; the memory is
// the slave and drives rd combinationally from a and its contents.
interface ram_v_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (
    output we,
    output a,
    output wd,
    input  rd
  );

  modport slave (
    input  we,
    input  a,
    input  wd,
    output rd
  );
endinterface : ram_v_if

// File: rtl/ram_v.sv
// ram_v: word-organised 32-bit data memory for the CPU memory stage.
// One synchronous write port, one combinational read port, both addressed by
// the same byte address. a[1:0] are ignored, so any byte address selects its
// containing word. Reset is synchronous and clears every word, so the storage
// is a register array rather than a block RAM.
//
// Optional feature macro: RAM_V_RANGE_CHECK_EN
//   defined   : addresses with a[31:AW+2] != 0 read as zero and never write
//   undefined : upper address bits are ignored, the index wraps modulo DEPTH
module ram_v #(
  parameter int DEPTH = 64
) (
  input  logic    clk,
  input  logic    rst,
  ram_v_if.slave  bus
);
  // Word-index width follows from DEPTH; kept local so it cannot drift.
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_reg [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          wr_en;
  logic [31:0]   rd_next;

  // Byte-offset bits never take part in the access.
  logic          unused_byte_bits;

  assign idx              = bus.a[AW+1:2];
  assign unused_byte_bits = ^bus.a[1:0];

`ifdef RAM_V_RANGE_CHECK_EN
  // Anything above the last word is out of range: no write, reads return zero.
  assign in_range = (bus.a[31:AW+2] == '0);
`else
  // Upper bits are ignored, so the address space aliases every DEPTH words.
  logic unused_upper_bits;
  assign unused_upper_bits = ^bus.a[31:AW+2];
  assign in_range          = 1'b1;
`endif

  // A store commits only when enabled and addressed inside the array; a
  // reset on the same edge takes precedence in the register process.
  assign wr_en = bus.we && in_range;

  // Storage: synchronous clear of every word, otherwise a single-word store.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[idx] <= bus.wd;
    end
  end

  // Combinational read with no bypass: during a store rd shows the old word
  // until the edge, then the new one.
  always_comb begin
    rd_next = '0;
    if (in_range) begin
      rd_next = mem_reg[idx];
    end
  end

  assign bus.rd = rd_next;
endmodule : ram_v

// File: tb/tb_ram_v.sv
// tb_ram_v: directed self-checking bench for ram_v (DEPTH = 64).
module tb_ram_v;
  localparam int DEPTH = 64;

  logic clk;
  logic rst;
  int   vectors;
  int   errors;

  ram_v_if bus ();

  ram_v #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare current rd against an expected word.
  task automatic check(input string tag, input logic [31:0] exp);
    vectors++;
    assert (bus.rd === exp) else begin
      errors++;
      $error("FAIL %s: rd=%h expected=%h", tag, bus.rd, exp);
    end
    $display("vec %0d %s a=%h rd=%h exp=%h", vectors, tag, bus.a, bus.rd, exp);
  endtask

  // Point the read port at an address and check the combinational result.
  task automatic read_at(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.a = addr;
    #1;
    check(tag, exp);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst     = 1'b1;
    bus.we  = 1'b0;
    bus.a   = '0;
    bus.wd  = '0;

    // Reset state
    tick();
    rst = 1'b0;
    read_at("reset_a0", 32'd0, 32'd0);
    read_at("reset_a100", 32'd100, 32'd0);

    // 1. store 24 at word 0
    bus.we = 1'b1; bus.a = 32'd0; bus.wd = 32'd24;
    tick();
    bus.we = 1'b0;
    read_at("store_a0", 32'd0, 32'd24);

    // 2. unaligned store at a=25 -> word 6
    bus.we = 1'b1; bus.a = 32'd25; bus.wd = 32'd128;
    tick();
    bus.we = 1'b0;
    read_at("unal_a25", 32'd25, 32'd128);
    read_at("unal_a24", 32'd24, 32'd128);
    read_at("unal_a27", 32'd27, 32'd128);
    read_at("unal_a0", 32'd0, 32'd24);
    read_at("unal_a28", 32'd28, 32'd0);

    // 3. write disabled with X address/data
    bus.we = 1'b0; bus.a = 'x; bus.wd = 'x;
    tick(); tick(); tick();
    read_at("wedis_a0", 32'd0, 32'd24);
    read_at("wedis_a24", 32'd24, 32'd128);

    // 4. reset clears everything and beats a concurrent write
    rst = 1'b1; bus.we = 1'b1; bus.a = 32'd0; bus.wd = 32'd99;
    tick();
    rst = 1'b0; bus.we = 1'b0;
    read_at("rstpri_a0", 32'd0, 32'd0);
    read_at("rstpri_a25", 32'd25, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      read_at($sformatf("rstclr_w%0d", i), 32'(i * 4), 32'd0);
    end

    // 5. read-during-write: old word before the edge, new word after
    bus.we = 1'b1; bus.a = 32'd24; bus.wd = 32'd5;
    tick();
    bus.we = 1'b1; bus.a = 32'd24; bus.wd = 32'd7;
    #1;
    check("rdw_before", 32'd5);
    tick();
    bus.we = 1'b0;
    read_at("rdw_after", 32'd24, 32'd7);

    // Back-to-back writes to one word: last wins
    bus.we = 1'b1; bus.a = 32'd8; bus.wd = 32'd1;
    tick();
    bus.wd = 32'd2;
    tick();
    bus.we = 1'b0;
    read_at("b2b_last", 32'd8, 32'd2);
    read_at("b2b_other", 32'd24, 32'd7);

    // 6. out-of-range address 4*DEPTH, with word 0 preloaded to 33
    bus.we = 1'b1; bus.a = 32'd0; bus.wd = 32'd33;
    tick();
    bus.a = 32'(4 * DEPTH); bus.wd = 32'd11;
    tick();
    bus.we = 1'b0;
`ifdef RAM_V_RANGE_CHECK_EN
    read_at("oor_rd", 32'(4 * DEPTH), 32'd0);
    read_at("oor_w0", 32'd0, 32'd33);
    read_at("oor_hi", 32'h8000_0000, 32'd0);
`else
    read_at("wrap_w0", 32'd0, 32'd11);
    read_at("wrap_rd", 32'(4 * DEPTH), 32'd11);
    read_at("wrap_hi", 32'h8000_0018, 32'd7);
`endif

    // Reset in the middle of a store sequence drops that write and earlier ones
    bus.we = 1'b1; bus.a = 32'd12; bus.wd = 32'd44;
    tick();
    rst = 1'b1; bus.a = 32'd16; bus.wd = 32'd55;
    tick();
    rst = 1'b0; bus.we = 1'b0;
    read_at("midrst_a12", 32'd12, 32'd0);
    read_at("midrst_a16", 32'd16, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule : tb_ram_v

// File: doc/ram_v.md
# ram_v

Word-organised 32-bit data memory for the pipelined CPU's memory stage. It has one synchronous write port and one asynchronous (combinational) read port. Both ports share a single byte address from the ALU result. Stores from the MEM stage commit on the rising clock edge, and loads see the addressed word in the same cycle.

## Interface
Parameters:
- `DEPTH`, 64: number of 32-bit words; must be a power of two, 2..4096.
- `AW`, clog2(DEPTH): word-index width, derived; do not override.

Ports:
- `clk`, input, 1: clock. All state changes occur on the rising edge.
- `rst`, input, 1: one clock; reset is synchronous and active-high.
- `we`, input, 1: write enable, sampled on the rising edge of `clk`.
- `a`, input, 32: byte address, shared by the read and write ports.
- `wd`, input, 32: write data.
- `rd`, output, 32: read data, combinational from `a` and the memory contents.

## Operation
Address mapping:
- Word index = `a[AW+1:2]`.
- `a[1:0]` is ignored: no alignment fault, and the access covers the whole containing word. For example, `a`=25 maps to word 6, the same word as `a`=24 through 27.
- `a[31:AW+2]` is handled according to Configuration.

Write:
- On a rising edge with `rst`=0 and `we`=1, the memory word at the index is loaded with `wd`.
- With `we`=0 nothing is written, whatever `a` and `wd` are (including X/Z).

Read:
- `rd` = memory word at the index, purely combinational, with no enable.

Reset:
- On a rising edge with `rst`=1, every word is cleared to 32'h0.
- `rst` has priority over `we`. A write requested in a reset cycle is discarded.

Power-up:
- Contents are undefined until the first reset edge.
- The CPU reset sequence must assert `rst` for at least one edge.

## Timing
- Write latency is 1 edge. New data is visible on `rd` immediately after the edge, within combinational delay, when `a` still points at that word.
- Read latency is 0 cycles. `rd` follows any change of `a` in the same cycle.
- Read-during-write to the same word: before the edge `rd` shows the old word; after the edge it shows `wd`. There is no write-through bypass.
- After a reset edge `rd` = 0 for every address until the next write.
- `rst` asserted in the middle of a store sequence: the write on that edge is lost, and all earlier writes are cleared.
- Back-to-back writes to the same word on consecutive edges: the last write wins.

## Configuration
Macro `RAM_V_RANGE_CHECK_EN`.

When defined:
- Any address with `a[31:AW+2]` ≠ 0 is out of range.
- For an out-of-range address, `rd` = 32'h0.
- Writes to an out-of-range address are ignored.

When undefined:
- Upper address bits are ignored and the index wraps modulo `DEPTH`. For example, `a` = 4·`DEPTH` aliases `a`=0.

## Test plan
1. Reset, then store at 0: assert `rst` for 1 edge, then `we`=1, `a`=0, `wd`=24 for 1 edge, then `we`=0, `a`=0. Required: `rd`=24.
2. Unaligned store: `we`=1, `a`=25, `wd`=128 for 1 edge, then `we`=0, `a`=25. Required: `rd`=128. Also required: `a`=24 returns 128, and `a`=0 still returns 24.
3. Write disabled with X inputs: `we`=0, `a`=X, `wd`=X for several edges. Required: words 0 and 6 still read 24 and 128.
4. Reset clears memory and has priority: after scenarios 1 and 2, drive `rst`=1 and `we`=1, `a`=0, `wd`=99 for 1 edge. Required: `rd`=0 at `a`=0, at `a`=25, and at every word index.
5. Read-during-write:
   - Setup: word 6 = 5.
   - Stimulus: `we`=1, `a`=24, `wd`=7 for 1 edge.
   - Required: `rd`=5 before the edge and `rd`=7 after it.
6. Out-of-range address: write 11 at `a`=4·`DEPTH`.
   - With `RAM_V_RANGE_CHECK_EN` defined: `rd` at that address = 0 and word 0 is unchanged.
   - Without the macro: word 0 = 11.
